// File: rtl/dma_fifo_controller_pkg.sv
// Shared DMA constants: default buffer geometry and the pointer-width helper.
package dma_fifo_controller_pkg;

  localparam int DMA_DEFAULT_WIDTH = 32;
  localparam int DMA_DEFAULT_DEPTH = 512;
  localparam int DMA_DEFAULT_BURST = 16;

  // Pointer width: address bits plus one wrap bit.
  function automatic int dmaPtrWidth(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/dma_fifo_controller_ssram.sv
// Dual-port synchronous SRAM with registered read data on port B.
// Both ports are expected to run from the same clock; port A wins a
// same-cycle write conflict.
module dma_fifo_controller_ssram
  import dma_fifo_controller_pkg::*;
#(
  parameter int bitwidth       = DMA_DEFAULT_WIDTH,
  parameter int nrOfEntries    = DMA_DEFAULT_DEPTH,
  parameter int readAfterWrite = 0
) (
  input  logic                           clockA,
  input  logic                           clockB,
  input  logic                           writeEnableA,
  input  logic [$clog2(nrOfEntries)-1:0] addressA,
  input  logic [bitwidth-1:0]            dataInA,
  input  logic                           writeEnableB,
  input  logic [$clog2(nrOfEntries)-1:0] addressB,
  input  logic [bitwidth-1:0]            dataInB,
  output logic [bitwidth-1:0]            dataOutB
);

  logic [bitwidth-1:0] mem [nrOfEntries];

  // Storage update: port A write has priority over port B write.
  always_ff @(posedge clockA) begin
    if (writeEnableA) begin
      mem[addressA] <= dataInA;
    end else if (writeEnableB) begin
      mem[addressB] <= dataInB;
    end
  end

  // Registered read; without read-after-write a same-edge write returns old data.
  always_ff @(posedge clockB) begin
    if ((readAfterWrite != 0) && writeEnableA && (addressA == addressB)) begin
      dataOutB <= dataInA;
    end else begin
      dataOutB <= mem[addressB];
    end
  end

endmodule

// File: rtl/dma_fifo_controller.sv
// Circular-buffer controller for the DMA transfer path. Sequences one
// dual-port SSRAM: port A takes pushes, port B keeps the head word in its
// output register so popData is available without an extra cycle.
module dma_fifo_controller
  import dma_fifo_controller_pkg::*;
#(
  parameter int bitwidth    = DMA_DEFAULT_WIDTH,
  parameter int nrOfEntries = DMA_DEFAULT_DEPTH,
  parameter int burstSize   = DMA_DEFAULT_BURST
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  flush,
  input  logic [bitwidth-1:0]                   pushData,
  input  logic                                  pushValid,
  output logic                                  pushReady,
  output logic [bitwidth-1:0]                   popData,
  output logic                                  popValid,
  input  logic                                  popReady,
  output logic [dmaPtrWidth(nrOfEntries)-1:0]   fillLevel,
  output logic                                  burstSpaceAvailable,
  output logic                                  burstDataAvailable
);

  localparam int AW = $clog2(nrOfEntries);
  localparam int PW = dmaPtrWidth(nrOfEntries);
  localparam logic [PW-1:0] DEPTH_P = PW'(nrOfEntries);
  localparam logic [PW-1:0] BURST_P = PW'(burstSize);

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtrVis;
  logic [PW-1:0] visLevel;
  logic [PW-1:0] freeLevel;
  logic          full;
  logic          pushFire;
  logic          popFire;
  logic          ramWrite;
  logic [AW-1:0] rdAddrNext;

  // Occupancy seen by the producer side counts every accepted word; the
  // consumer side only counts words that have had one edge to settle in RAM.
  assign fillLevel = wrPtr - rdPtr;
  assign visLevel  = wrPtrVis - rdPtr;
  assign freeLevel = DEPTH_P - fillLevel;
  assign full      = (fillLevel == DEPTH_P);

  // No bypass when full: a pop in the same cycle does not open the push side.
  assign pushReady = !full;
  assign popValid  = (rdPtr != wrPtrVis);
  assign pushFire  = pushValid && pushReady;
  assign popFire   = popValid && popReady;

  // A flush discards any concurrent push, including its RAM write.
  assign ramWrite  = pushFire && !flush;

  assign burstSpaceAvailable = (freeLevel >= BURST_P);
  assign burstDataAvailable  = (visLevel >= BURST_P);

  // Look one entry ahead on a pop so the RAM register always holds the head.
  assign rdAddrNext = rdPtr[AW-1:0] + {{(AW-1){1'b0}}, popFire};

  // Pointer state: async reset, synchronous flush with priority over traffic.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      wrPtrVis <= '0;
    end else if (flush) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      wrPtrVis <= '0;
    end else begin
      if (pushFire) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popFire) begin
        rdPtr <= rdPtr + 1'b1;
      end
      wrPtrVis <= wrPtr;
    end
  end

  dma_fifo_controller_ssram #(
    .bitwidth      (bitwidth),
    .nrOfEntries   (nrOfEntries),
    .readAfterWrite(0)
  ) dualPortSSRAM (
    .clockA      (clock),
    .clockB      (clock),
    .writeEnableA(ramWrite),
    .addressA    (wrPtr[AW-1:0]),
    .dataInA     (pushData),
    .writeEnableB(1'b0),
    .addressB    (rdAddrNext),
    .dataInB     ({bitwidth{1'b0}}),
    .dataOutB    (popData)
  );

endmodule

// File: tb/tb_dma_fifo_controller.sv
// Directed self-checking bench for dma_fifo_controller (default geometry:
// 32-bit words, 512 entries, burst of 16).
module tb_dma_fifo_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic [31:0] pushData;
  logic        pushValid;
  logic        pushReady;
  logic [31:0] popData;
  logic        popValid;
  logic        popReady;
  logic [9:0]  fillLevel;
  logic        burstSpaceAvailable;
  logic        burstDataAvailable;

  int checks   = 0;
  int failures = 0;

  dma_fifo_controller dut (
    .clock              (clock),
    .reset              (reset),
    .flush              (flush),
    .pushData           (pushData),
    .pushValid          (pushValid),
    .pushReady          (pushReady),
    .popData            (popData),
    .popValid           (popValid),
    .popReady           (popReady),
    .fillLevel          (fillLevel),
    .burstSpaceAvailable(burstSpaceAvailable),
    .burstDataAvailable (burstDataAvailable)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_pushReady"}, {31'd0, pushReady}, 32'd1);
    check({tag, "_popValid"},  {31'd0, popValid},  32'd0);
    check({tag, "_fillLevel"}, {22'd0, fillLevel}, 32'd0);
    check({tag, "_bsa"},       {31'd0, burstSpaceAvailable}, 32'd1);
    check({tag, "_bda"},       {31'd0, burstDataAvailable},  32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dataErr;
    int fillErr;
    logic [31:0] wrVal;
    logic [31:0] rdVal;

    reset = 1'b1; flush = 1'b0; pushData = '0; pushValid = 1'b0; popReady = 1'b0;
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();

    // Single word: visible one edge after acceptance.
    pushData = 32'hA5A5_0001; pushValid = 1'b1;
    tick();
    pushValid = 1'b0;
    check("single_fill_E0", {22'd0, fillLevel}, 32'd1);
    check("single_vld_E0",  {31'd0, popValid},  32'd0);
    tick();
    check("single_vld_E1",  {31'd0, popValid},  32'd1);
    check("single_data",    popData, 32'hA5A5_0001);
    popReady = 1'b1;
    tick();
    popReady = 1'b0;
    check("single_pop_vld",  {31'd0, popValid},  32'd0);
    check("single_pop_fill", {22'd0, fillLevel}, 32'd0);

    // Fill completely with 0..511, probing burst flags on the way.
    for (int i = 0; i < 512; i++) begin
      pushData = i; pushValid = 1'b1;
      tick();
      if (i == 14) check("burst_15_bda", {31'd0, burstDataAvailable}, 32'd0);
      if (i == 15) check("burst_16_bda_E", {31'd0, burstDataAvailable}, 32'd0);
      if (i == 16) check("burst_16_bda_E1", {31'd0, burstDataAvailable}, 32'd1);
      if (i == 495) check("space_496_bsa", {31'd0, burstSpaceAvailable}, 32'd1);
      if (i == 496) check("space_497_bsa", {31'd0, burstSpaceAvailable}, 32'd0);
    end
    check("full_pushReady", {31'd0, pushReady}, 32'd0);
    check("full_fill",      {22'd0, fillLevel}, 32'd512);
    pushData = 32'hDEAD_BEEF;
    tick();
    pushValid = 1'b0;
    check("full_reject_fill", {22'd0, fillLevel}, 32'd512);

    // Drain in order.
    popReady = 1'b1;
    dataErr = 0;
    for (int j = 0; j < 512; j++) begin
      if (popValid !== 1'b1 || popData !== j) begin
        if (dataErr == 0) $display("drain first bad index %0d data=%0h", j, popData);
        dataErr++;
      end
      tick();
      if (j == 0) check("drain_pushReady", {31'd0, pushReady}, 32'd1);
      if (j == 14) check("drain_497_bsa", {31'd0, burstSpaceAvailable}, 32'd0);
      if (j == 15) check("drain_496_bsa", {31'd0, burstSpaceAvailable}, 32'd1);
    end
    popReady = 1'b0;
    check("drain_order_errors", dataErr, 32'd0);
    check("drain_empty_vld",  {31'd0, popValid},  32'd0);
    check("drain_empty_fill", {22'd0, fillLevel}, 32'd0);

    // Streaming: prefill 8, then push and pop every cycle for 2000 cycles.
    wrVal = 32'hC000_0000;
    rdVal = 32'hC000_0000;
    for (int i = 0; i < 8; i++) begin
      pushData = wrVal; pushValid = 1'b1;
      tick();
      wrVal++;
    end
    pushValid = 1'b0;
    tick();
    dataErr = 0;
    fillErr = 0;
    pushValid = 1'b1; popReady = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      pushData = wrVal;
      if (popValid !== 1'b1 || popData !== rdVal) dataErr++;
      if (fillLevel !== 10'd8) fillErr++;
      tick();
      wrVal++;
      rdVal++;
    end
    pushValid = 1'b0; popReady = 1'b0;
    check("stream_data_errors", dataErr, 32'd0);
    check("stream_fill_errors", fillErr, 32'd0);
    check("stream_head", popData, rdVal);

    // Bring the level to 100, then flush with a push and pop pending.
    for (int i = 0; i < 92; i++) begin
      pushData = wrVal; pushValid = 1'b1;
      tick();
      wrVal++;
    end
    pushValid = 1'b0;
    check("preflush_fill", {22'd0, fillLevel}, 32'd100);
    flush = 1'b1; pushValid = 1'b1; pushData = 32'hBAD0_BAD0; popReady = 1'b1;
    check("flush_pushReady", {31'd0, pushReady}, 32'd1);
    tick();
    flush = 1'b0; pushValid = 1'b0; popReady = 1'b0;
    check("flush_fill", {22'd0, fillLevel}, 32'd0);
    check("flush_vld",  {31'd0, popValid},  32'd0);
    pushData = 32'h1234_5678; pushValid = 1'b1;
    tick();
    pushValid = 1'b0;
    tick();
    check("postflush_vld",  {31'd0, popValid},  32'd1);
    check("postflush_data", popData, 32'h1234_5678);
    check("postflush_fill", {22'd0, fillLevel}, 32'd1);
    tick();
    check("hold_data", popData, 32'h1234_5678);
    popReady = 1'b1;
    tick();
    popReady = 1'b0;

    // Async reset during streaming: outputs clear without an edge.
    for (int i = 0; i < 4; i++) begin
      pushData = 32'h7700_0000 + i; pushValid = 1'b1;
      tick();
    end
    popReady = 1'b1;
    for (int i = 4; i < 10; i++) begin
      pushData = 32'h7700_0000 + i;
      tick();
    end
    #2;
    reset = 1'b1;
    #1;
    checkResetValues("async");
    pushValid = 1'b0; popReady = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Resume after reset.
    for (int i = 0; i < 3; i++) begin
      pushData = 32'hE000_0000 + i; pushValid = 1'b1;
      tick();
    end
    pushValid = 1'b0;
    tick();
    check("resume_fill", {22'd0, fillLevel}, 32'd3);
    popReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("resume_data", popData, 32'hE000_0000 + i);
      tick();
    end
    popReady = 1'b0;
    check("resume_empty", {31'd0, popValid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_fifo_controller.md
# dma_fifo_controller

Circular-buffer (FIFO) controller that sequences one dual-port SSRAM instance for the DMA block. Port A is the write side, port B the read side, both on a single clock. The block exposes valid/ready push and pop interfaces, and fill/burst flags that the DMA bus master uses to decide when to start bus bursts. It sits between the DMA bus-interface state machine and the transfer datapath.

## Interface
- bitwidth, 32, data word width
- nrOfEntries, 512, buffer depth; power of two, ≥ 4
- burstSize, 16, words per bus burst; 1 ≤ burstSize ≤ nrOfEntries
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  reset is asynchronous and active-high
- flush  in  1  synchronous clear of buffer contents
- pushData  in  bitwidth  word to store
- pushValid  in  1  producer offers pushData
- pushReady  out  1  buffer accepts a word this cycle
- popData  out  bitwidth  head word; meaningful only while popValid=1
- popValid  out  1  head word readable
- popReady  in  1  consumer takes head word
- fillLevel  out  $clog2(nrOfEntries)+1  words written and not yet popped
- burstSpaceAvailable  out  1  free entries ≥ burstSize
- burstDataAvailable  out  1  readable entries ≥ burstSize

## Operation
- Pointers wrPtr, rdPtr and wrPtrVis each have $clog2(nrOfEntries)+1 bits. The MSB is the wrap bit. The low bits address the RAM.
- fillLevel = wrPtr − rdPtr, computed modulo 2^(AW+1). full ⇔ fillLevel == nrOfEntries.
- pushReady = !full. There is no push/pop bypass when full: a simultaneous pop does not raise pushReady in the same cycle.
- A push fires when pushValid && pushReady. RAM port A writes pushData at wrPtr[AW−1:0], and wrPtr increments.
- wrPtrVis <= wrPtr every cycle. A word becomes readable only one edge after it was written, which avoids the same-edge read-old-data behaviour of the RAM.
- popValid = (rdPtr != wrPtrVis).
- A pop fires when popValid && popReady, and rdPtr increments.
- RAM addressB is driven combinationally with rdPtr + (pop fires ? 1 : 0), low bits. The RAM output register therefore always holds the current head, and popData is wired directly to dataOutB.
- burstSpaceAvailable = (nrOfEntries − fillLevel) ≥ burstSize.
- burstDataAvailable = (wrPtrVis − rdPtr) ≥ burstSize.
- Pointer increments wrap naturally. An empty buffer is detected by full pointer equality; a full buffer is equal low bits with differing MSB.
- flush=1: wrPtr, rdPtr and wrPtrVis are set to 0 at the edge. flush has priority: a push or pop in the same cycle is discarded (not counted, not written). pushReady stays driven by the pre-flush state during that cycle.
- Reset mid-operation: all pointers clear immediately, regardless of a push or pop in progress. RAM contents are not cleared.

## Timing
- Reset values: pushReady=1, popValid=0, fillLevel=0, burstSpaceAvailable=1, burstDataAvailable=0.
- popData is not reset and is don't-care while popValid=0.
- Push-to-pop latency: a word accepted at edge E0 gives popValid=1 after edge E1, provided the buffer was otherwise empty.
- fillLevel updates after E0. burstDataAvailable lags fillLevel by one cycle.
- Throughput: one push and one pop per cycle sustained, including simultaneous push and pop at any level except full.
- popData changes only after an edge at which a pop fired, or while popValid=0. It is stable while popValid=1 && popReady=0.

## Structure
- Sub-module: one dualPortSSRAM instance.
  - bitwidth and nrOfEntries passed through, readAfterWrite=0.
  - clockA = clockB = clock; writeEnableB=0; dataInB=0.
- Shared DMA package/include holds:
  - default depth, width and burst constants;
  - a pointer-width constant function, $clog2(n)+1.
- Everything else is local. The pointer/flag logic is a single always block plus continuous assignments.

## Test plan
- Reset, then single push of 32'hA5A5_0001 at E0 → popValid=1 after E1, popData=32'hA5A5_0001, fillLevel=1. Pop → popValid=0, fillLevel=0.
- Push 512 words 0..511 with popReady=0 → pushReady=0 after the 512th, fillLevel=512. Then pop all → data 0..511 in order, with pushReady=1 after the first pop.
- Continuous simultaneous push/pop for 2000 cycles (nrOfEntries=512) → pointers wrap ≥3 times, no data loss or duplication, fillLevel constant.
- burstSize=16: push 15 → burstDataAvailable=0. 16th push at E → burstDataAvailable=1 after E+1. Fill to 497 → burstSpaceAvailable=0. Pop one → burstSpaceAvailable=1.
- With fillLevel=100, assert flush together with pushValid and popReady → fillLevel=0, popValid=0 next cycle, no word written. Next push is returned first.
- Assert reset asynchronously mid-cycle during streaming → outputs take their reset values immediately, without waiting for an edge. Streaming resumes correctly after deassert.
